// File: rtl/nn_bench_pkg.sv
// Shared constants and types for the NN benchmark frame driver.
//   WIDTH/NFRAC     : sample format (signed Q5.10, no arithmetic applied to it here)
//   INPUT_SIZE      : samples gathered per input frame
//   OUTPUT_SIZE     : results replayed per output frame
//   sample_t        : signed sample type
//   drv_state_t     : driver FSM states
package nn_bench_pkg;

    localparam int WIDTH       = 16;
    localparam int NFRAC       = 10;
    localparam int INPUT_SIZE  = 16;
    localparam int OUTPUT_SIZE = 5;

    localparam int IN_IDX_W  = $clog2(INPUT_SIZE);
    localparam int OUT_IDX_W = $clog2(OUTPUT_SIZE);

    typedef logic signed [WIDTH-1:0] sample_t;

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_FIRE  = 2'd1,
        S_WAIT  = 2'd2,
        S_DRAIN = 2'd3
    } drv_state_t;

endpackage

// File: rtl/nn_frame_driver_if.sv
// Bundle of the frame driver's stream and core-side signals.
//   s_*              : serial input sample stream (valid/ready)
//   nn_input_*       : parallel frame and fire strobe towards the NN core
//   nn_output_*      : result-valid level and results from the NN core
//   m_*              : serial result stream (valid/ready, index, last)
// Modports:
//   master : the frame driver itself
//   slave  : the environment around it (host stream, core, downstream sink)
interface nn_frame_driver_if;
    import nn_bench_pkg::*;

    logic                              s_valid;
    sample_t                           s_data;
    logic                              s_ready;

    logic                              nn_input_ready;
    sample_t [INPUT_SIZE-1:0]          nn_input_data;
    logic                              nn_output_ready;
    sample_t [OUTPUT_SIZE-1:0]         nn_output_data;

    logic                              m_valid;
    sample_t                           m_data;
    logic [OUT_IDX_W-1:0]              m_index;
    logic                              m_last;
    logic                              m_ready;

    modport master (
        input  s_valid, s_data, nn_output_ready, nn_output_data, m_ready,
        output s_ready, nn_input_ready, nn_input_data, m_valid, m_data, m_index, m_last
    );

    modport slave (
        output s_valid, s_data, nn_output_ready, nn_output_data, m_ready,
        input  s_ready, nn_input_ready, nn_input_data, m_valid, m_data, m_index, m_last
    );

endinterface

// File: rtl/nn_argmax.sv
// Combinational signed arg-max over OUTPUT_SIZE samples.
//   vals : candidate samples
//   idx  : index of the largest value; ties resolve to the lowest index
module nn_argmax
    import nn_bench_pkg::*;
(
    input  sample_t [OUTPUT_SIZE-1:0] vals,
    output logic [OUT_IDX_W-1:0]      idx
);

    always_comb begin
        sample_t best;
        idx  = '0;
        best = vals[0];
        for (int i = 1; i < OUTPUT_SIZE; i++) begin
            // Strict compare keeps the earliest index on ties.
            if (vals[i] > best) begin
                best = vals[i];
                idx  = OUT_IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/nn_frame_driver.sv
// Host-side driver for the fixed-point NN benchmark core.
// Gathers INPUT_SIZE serial samples into a parallel frame, pulses the core's
// input strobe, waits for a rising edge on the core's result-valid level,
// captures the results and replays them as a serial stream.
// Ports:
//   clk          : clock, rising edge
//   reset        : synchronous, active-low reset
//   bus          : nn_frame_driver_if.master (input stream, core, result stream)
//   busy         : high whenever the driver is not loading
//   timeout_err  : sticky flag, set when the core fails to answer in time
//   frame_count  : completed output frames, wraps at 16 bits
//   argmax_class : (NN_DRV_ARGMAX_EN only) index of largest captured result
//   argmax_valid : (NN_DRV_ARGMAX_EN only) high while results are drained
// Build option: define NN_DRV_ARGMAX_EN to add the arg-max outputs.
module nn_frame_driver
    import nn_bench_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                 clk,
    input  logic                 reset,
    nn_frame_driver_if.master    bus,
    output logic                 busy,
    output logic                 timeout_err,
    output logic [15:0]          frame_count
`ifdef NN_DRV_ARGMAX_EN
    ,
    output logic [OUT_IDX_W-1:0] argmax_class,
    output logic                 argmax_valid
`endif
);

    localparam bit WD_EN = (TIMEOUT_CYCLES > 0);
    localparam int WD_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WD_W-1:0]      WD_LAST  = WD_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [IN_IDX_W-1:0]  LOAD_END = IN_IDX_W'(INPUT_SIZE - 1);
    localparam logic [OUT_IDX_W-1:0] DRAIN_END = OUT_IDX_W'(OUTPUT_SIZE - 1);

    drv_state_t                state;
    drv_state_t                state_d;
    logic [IN_IDX_W-1:0]       load_idx;
    logic [OUT_IDX_W-1:0]      drain_idx;
    logic [WD_W-1:0]           wd_cnt;
    logic                      nrdy_prev;
    sample_t [INPUT_SIZE-1:0]  in_buf;
    sample_t [OUTPUT_SIZE-1:0] out_buf;

    logic load_acc;
    logic drain_acc;
    logic out_edge;
    logic capture;
    logic timeout_hit;

    // s_ready is held low while reset is asserted so every output reads 0
    // during reset, even though the FSM already sits in S_LOAD.
    assign bus.s_ready        = (state == S_LOAD) && reset;
    assign bus.nn_input_ready = (state == S_FIRE);
    assign bus.nn_input_data  = in_buf;
    assign bus.m_valid        = (state == S_DRAIN);
    assign bus.m_data         = out_buf[drain_idx];
    assign bus.m_index        = drain_idx;
    assign bus.m_last         = (state == S_DRAIN) && (drain_idx == DRAIN_END);
    assign busy               = (state != S_LOAD);

    assign load_acc  = bus.s_valid && bus.s_ready;
    assign drain_acc = (state == S_DRAIN) && bus.m_ready;
    // Capture only on a fresh rising edge so a level left high from a
    // previous frame can never be mistaken for a new result.
    assign out_edge  = bus.nn_output_ready && !nrdy_prev;

    always_comb begin
        state_d     = state;
        capture     = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            S_LOAD: begin
                if (load_acc && (load_idx == LOAD_END)) begin
                    state_d = S_FIRE;
                end
            end
            S_FIRE: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (out_edge) begin
                    capture = 1'b1;
                    state_d = S_DRAIN;
                end else if (WD_EN && (wd_cnt == WD_LAST)) begin
                    timeout_hit = 1'b1;
                    state_d     = S_LOAD;
                end
            end
            S_DRAIN: begin
                if (drain_acc && (drain_idx == DRAIN_END)) begin
                    state_d = S_LOAD;
                end
            end
            default: begin
                state_d = S_LOAD;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= S_LOAD;
            load_idx    <= '0;
            drain_idx   <= '0;
            wd_cnt      <= '0;
            nrdy_prev   <= 1'b0;
            in_buf      <= '0;
            out_buf     <= '0;
            timeout_err <= 1'b0;
            frame_count <= '0;
        end else begin
            state     <= state_d;
            nrdy_prev <= bus.nn_output_ready;

            if (load_acc) begin
                in_buf[load_idx] <= bus.s_data;
                load_idx         <= (load_idx == LOAD_END) ? '0 : load_idx + 1'b1;
            end

            // wd_cnt holds the number of S_WAIT cycles already elapsed.
            if (state == S_FIRE) begin
                wd_cnt <= '0;
            end else if (state == S_WAIT) begin
                wd_cnt <= wd_cnt + 1'b1;
            end

            if (capture) begin
                out_buf <= bus.nn_output_data;
            end

            if (timeout_hit) begin
                timeout_err <= 1'b1;
            end

            if (drain_acc) begin
                if (drain_idx == DRAIN_END) begin
                    drain_idx   <= '0;
                    frame_count <= frame_count + 16'd1;
                end else begin
                    drain_idx <= drain_idx + 1'b1;
                end
            end
        end
    end

`ifdef NN_DRV_ARGMAX_EN
    logic [OUT_IDX_W-1:0] argmax_next;

    // Evaluated on the live core outputs so the class is ready together
    // with the captured results.
    nn_argmax u_argmax (
        .vals (bus.nn_output_data),
        .idx  (argmax_next)
    );

    assign argmax_valid = (state == S_DRAIN);

    always_ff @(posedge clk) begin
        if (!reset) begin
            argmax_class <= '0;
        end else if (capture) begin
            argmax_class <= argmax_next;
        end
    end
`endif

endmodule

// File: tb/tb_nn_frame_driver.sv
// Directed self-checking bench for nn_frame_driver.
// Two instances share clock and reset: dut uses the default watchdog, dut_wd
// uses an 8-cycle watchdog and never receives a core response.
module tb_nn_frame_driver;
    import nn_bench_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    nn_frame_driver_if bus ();
    nn_frame_driver_if bus_wd ();

    logic        busy, timeout_err;
    logic [15:0] frame_count;
    logic        busy_wd, timeout_err_wd;
    logic [15:0] frame_count_wd;
`ifdef NN_DRV_ARGMAX_EN
    logic [OUT_IDX_W-1:0] argmax_class, argmax_class_wd;
    logic                 argmax_valid, argmax_valid_wd;
`endif

    nn_frame_driver #(.TIMEOUT_CYCLES(4096)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .busy        (busy),
        .timeout_err (timeout_err),
        .frame_count (frame_count)
`ifdef NN_DRV_ARGMAX_EN
        ,
        .argmax_class (argmax_class),
        .argmax_valid (argmax_valid)
`endif
    );

    nn_frame_driver #(.TIMEOUT_CYCLES(8)) dut_wd (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus_wd),
        .busy        (busy_wd),
        .timeout_err (timeout_err_wd),
        .frame_count (frame_count_wd)
`ifdef NN_DRV_ARGMAX_EN
        ,
        .argmax_class (argmax_class_wd),
        .argmax_valid (argmax_valid_wd)
`endif
    );

    int checks   = 0;
    int failures = 0;

    sample_t frame1 [INPUT_SIZE];
    sample_t frame2 [INPUT_SIZE];
    sample_t out1 [OUTPUT_SIZE];
    sample_t out2 [OUTPUT_SIZE];
    sample_t out3 [OUTPUT_SIZE];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_samples(input sample_t v [INPUT_SIZE], input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            bus.s_valid = 1'b1;
            bus.s_data  = v[i];
            tick();
        end
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
    endtask

    task automatic respond(input sample_t r [OUTPUT_SIZE], input int delay);
        repeat (delay) tick();
        for (int i = 0; i < OUTPUT_SIZE; i++) bus.nn_output_data[i] = r[i];
        bus.nn_output_ready = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick();
        tick();
        checks++;
        if (busy !== 1'b0 || timeout_err !== 1'b0 || frame_count !== 16'd0 ||
            bus.nn_input_ready !== 1'b0 || bus.m_valid !== 1'b0 || bus.m_data !== 16'sd0 ||
            bus.m_index !== '0 || bus.m_last !== 1'b0 || bus.nn_input_data !== '0) begin
            failures++;
            $display("FAIL reset_state busy=%b tout=%b fc=%0d strobe=%b mv=%b md=%0d want all 0",
                     busy, timeout_err, frame_count, bus.nn_input_ready, bus.m_valid, bus.m_data);
        end
`ifdef NN_DRV_ARGMAX_EN
        checks++;
        if (argmax_class !== '0 || argmax_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_argmax class=%0d valid=%b want 0 0", argmax_class, argmax_valid);
        end
`endif
        reset = 1'b1;
        tick();
        checks++;
        if (bus.s_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_release s_ready=%b busy=%b want 1 0", bus.s_ready, busy);
        end
    endtask

    task automatic test_frame1();
        send_samples(frame1, 0, INPUT_SIZE - 1);
        checks++;
        if (bus.nn_input_ready !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL early_strobe strobe=%b busy=%b want 0 0", bus.nn_input_ready, busy);
        end
        send_samples(frame1, INPUT_SIZE - 1, INPUT_SIZE);
        checks++;
        if (bus.nn_input_ready !== 1'b1 || bus.s_ready !== 1'b0) begin
            failures++;
            $display("FAIL strobe_latency strobe=%b s_ready=%b want 1 0", bus.nn_input_ready, bus.s_ready);
        end
        checks++;
        if (bus.nn_input_data[0] !== frame1[0] || bus.nn_input_data[15] !== frame1[15] ||
            bus.nn_input_data[7] !== frame1[7]) begin
            failures++;
            $display("FAIL frame1_data d0=%0d d7=%0d d15=%0d want -304 -144 430",
                     bus.nn_input_data[0], bus.nn_input_data[7], bus.nn_input_data[15]);
        end
        tick();
        checks++;
        if (bus.nn_input_ready !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL strobe_width strobe=%b busy=%b want 0 1", bus.nn_input_ready, busy);
        end
        repeat (19) tick();
        checks++;
        if (bus.m_valid !== 1'b0 || timeout_err !== 1'b0 || bus.nn_input_data[0] !== frame1[0]) begin
            failures++;
            $display("FAIL wait_state mv=%b tout=%b d0=%0d want 0 0 -304", bus.m_valid, timeout_err,
                     bus.nn_input_data[0]);
        end
        bus.m_ready = 1'b1;
        respond(out1, 0);
        tick();
        for (int k = 0; k < OUTPUT_SIZE; k++) begin
            checks++;
            if (bus.m_valid !== 1'b1 || bus.m_data !== out1[k] || bus.m_index !== OUT_IDX_W'(k) ||
                bus.m_last !== (k == OUTPUT_SIZE - 1)) begin
                failures++;
                $display("FAIL drain1[%0d] mv=%b data=%0d idx=%0d last=%b want 1 %0d %0d %b",
                         k, bus.m_valid, bus.m_data, bus.m_index, bus.m_last, out1[k], k, k == 4);
            end
`ifdef NN_DRV_ARGMAX_EN
            checks++;
            if (argmax_class !== OUT_IDX_W'(2) || argmax_valid !== 1'b1) begin
                failures++;
                $display("FAIL argmax1 class=%0d valid=%b want 2 1", argmax_class, argmax_valid);
            end
`endif
            tick();
        end
        checks++;
        if (busy !== 1'b0 || frame_count !== 16'd1 || bus.m_valid !== 1'b0 || bus.s_ready !== 1'b1) begin
            failures++;
            $display("FAIL frame1_done busy=%b fc=%0d mv=%b s_ready=%b want 0 1 0 1",
                     busy, frame_count, bus.m_valid, bus.s_ready);
        end
        bus.nn_output_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        int  k;
        int  c;
        logic rdy;
        send_samples(frame2, 0, INPUT_SIZE);
        bus.m_ready = 1'b0;
        respond(out2, 3);
        tick();
        k = 0;
        c = 0;
        while (k < OUTPUT_SIZE && c < 40) begin
            bus.m_ready = ((c % 2) == 0);
            checks++;
            if (bus.m_valid !== 1'b1 || bus.m_data !== out2[k] || bus.m_index !== OUT_IDX_W'(k) ||
                bus.m_last !== (k == OUTPUT_SIZE - 1)) begin
                failures++;
                $display("FAIL bp_drain[c=%0d] mv=%b data=%0d idx=%0d last=%b want 1 %0d %0d %b",
                         c, bus.m_valid, bus.m_data, bus.m_index, bus.m_last, out2[k], k, k == 4);
            end
`ifdef NN_DRV_ARGMAX_EN
            checks++;
            if (argmax_class !== OUT_IDX_W'(1)) begin
                failures++;
                $display("FAIL argmax_tie class=%0d want 1", argmax_class);
            end
`endif
            rdy = bus.m_ready;
            tick();
            c++;
            if (rdy) k++;
        end
        checks++;
        if (k != OUTPUT_SIZE || busy !== 1'b0 || frame_count !== 16'd2) begin
            failures++;
            $display("FAIL bp_done accepted=%0d busy=%b fc=%0d want 5 0 2", k, busy, frame_count);
        end
        bus.m_ready = 1'b1;
    endtask

    task automatic test_stale_level();
        // nn_output_ready is still high from the previous frame.
        for (int i = 0; i < OUTPUT_SIZE; i++) bus.nn_output_data[i] = out3[i];
        send_samples(frame1, 0, INPUT_SIZE);
        checks++;
        if (bus.nn_input_ready !== 1'b1) begin
            failures++;
            $display("FAIL stale_strobe strobe=%b want 1", bus.nn_input_ready);
        end
        repeat (12) tick();
        checks++;
        if (bus.m_valid !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL stale_capture mv=%b busy=%b want 0 1", bus.m_valid, busy);
        end
        bus.nn_output_ready = 1'b0;
        tick();
        checks++;
        if (bus.m_valid !== 1'b0) begin
            failures++;
            $display("FAIL stale_fall mv=%b want 0", bus.m_valid);
        end
        bus.nn_output_ready = 1'b1;
        tick();
        for (int k = 0; k < OUTPUT_SIZE; k++) begin
            checks++;
            if (bus.m_valid !== 1'b1 || bus.m_data !== out3[k] || bus.m_index !== OUT_IDX_W'(k)) begin
                failures++;
                $display("FAIL stale_drain[%0d] mv=%b data=%0d idx=%0d want 1 %0d %0d",
                         k, bus.m_valid, bus.m_data, bus.m_index, out3[k], k);
            end
            tick();
        end
        checks++;
        if (busy !== 1'b0 || frame_count !== 16'd3) begin
            failures++;
            $display("FAIL stale_done busy=%b fc=%0d want 0 3", busy, frame_count);
        end
        bus.nn_output_ready = 1'b0;
    endtask

    task automatic test_watchdog();
        int n;
        for (int i = 0; i < INPUT_SIZE; i++) begin
            bus_wd.s_valid = 1'b1;
            bus_wd.s_data  = frame1[i];
            tick();
        end
        bus_wd.s_valid = 1'b0;
        checks++;
        if (bus_wd.nn_input_ready !== 1'b1) begin
            failures++;
            $display("FAIL wd_strobe strobe=%b want 1", bus_wd.nn_input_ready);
        end
        n = 0;
        while (busy_wd === 1'b1 && n < 20) begin
            tick();
            n++;
        end
        // One S_FIRE cycle plus eight S_WAIT cycles.
        checks++;
        if (n != 9) begin
            failures++;
            $display("FAIL wd_cycles got=%0d want 9", n);
        end
        checks++;
        if (timeout_err_wd !== 1'b1 || bus_wd.s_ready !== 1'b1 || frame_count_wd !== 16'd0 ||
            bus_wd.m_valid !== 1'b0) begin
            failures++;
            $display("FAIL wd_abort tout=%b s_ready=%b fc=%0d mv=%b want 1 1 0 0",
                     timeout_err_wd, bus_wd.s_ready, frame_count_wd, bus_wd.m_valid);
        end
        repeat (3) tick();
        checks++;
        if (timeout_err_wd !== 1'b1 || timeout_err !== 1'b0) begin
            failures++;
            $display("FAIL wd_sticky tout_wd=%b tout_main=%b want 1 0", timeout_err_wd, timeout_err);
        end
    endtask

    task automatic test_reset_mid();
        send_samples(frame2, 0, 7);
        reset = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0 || frame_count !== 16'd0 || bus.nn_input_data !== '0 ||
            bus.m_valid !== 1'b0 || bus.nn_input_ready !== 1'b0 || timeout_err_wd !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_load busy=%b fc=%0d d0=%0d mv=%b tout_wd=%b want 0 0 0 0 0",
                     busy, frame_count, bus.nn_input_data[0], bus.m_valid, timeout_err_wd);
        end
        reset = 1'b1;
        tick();
        send_samples(frame1, 0, INPUT_SIZE);
        respond(out1, 2);
        bus.m_ready = 1'b1;
        tick();
        tick();
        tick();
        checks++;
        if (bus.m_valid !== 1'b1 || bus.m_index !== OUT_IDX_W'(2) || bus.m_data !== out1[2]) begin
            failures++;
            $display("FAIL mid_drain_pos mv=%b idx=%0d data=%0d want 1 2 900", bus.m_valid, bus.m_index, bus.m_data);
        end
        reset = 1'b0;
        tick();
        checks++;
        if (bus.m_valid !== 1'b0 || bus.m_data !== 16'sd0 || bus.m_index !== '0 || bus.m_last !== 1'b0 ||
            busy !== 1'b0 || frame_count !== 16'd0 || bus.nn_input_data !== '0) begin
            failures++;
            $display("FAIL reset_mid_drain mv=%b data=%0d idx=%0d busy=%b fc=%0d want 0 0 0 0 0",
                     bus.m_valid, bus.m_data, bus.m_index, busy, frame_count);
        end
        reset = 1'b1;
        bus.nn_output_ready = 1'b0;
        tick();
        send_samples(frame2, 0, INPUT_SIZE);
        checks++;
        if (bus.nn_input_ready !== 1'b1 || bus.nn_input_data[0] !== frame2[0] ||
            bus.nn_input_data[15] !== frame2[15]) begin
            failures++;
            $display("FAIL fresh_frame strobe=%b d0=%0d d15=%0d want 1 %0d %0d",
                     bus.nn_input_ready, bus.nn_input_data[0], bus.nn_input_data[15], frame2[0], frame2[15]);
        end
        respond(out2, 5);
        tick();
        for (int k = 0; k < OUTPUT_SIZE; k++) begin
            checks++;
            if (bus.m_valid !== 1'b1 || bus.m_data !== out2[k] || bus.m_index !== OUT_IDX_W'(k) ||
                bus.m_last !== (k == OUTPUT_SIZE - 1)) begin
                failures++;
                $display("FAIL fresh_drain[%0d] mv=%b data=%0d idx=%0d last=%b want 1 %0d %0d %b",
                         k, bus.m_valid, bus.m_data, bus.m_index, bus.m_last, out2[k], k, k == 4);
            end
            tick();
        end
        checks++;
        if (busy !== 1'b0 || frame_count !== 16'd1) begin
            failures++;
            $display("FAIL fresh_done busy=%b fc=%0d want 0 1", busy, frame_count);
        end
        bus.nn_output_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout simulation did not finish checks=%0d failures=%0d", checks, failures);
        $fatal(1, "bench timeout");
    end

    initial begin
        frame1 = '{-16'sd304, 16'sd378, 16'sd253, -16'sd8, 16'sd123, 16'sd14, -16'sd399, -16'sd144,
                   -16'sd399, -16'sd629, -16'sd664, -16'sd537, -16'sd586, -16'sd376, 16'sd284, 16'sd430};
        for (int i = 0; i < INPUT_SIZE; i++) frame2[i] = sample_t'(i * 53 - 400);
        out1 = '{16'sd100, -16'sd50, 16'sd900, 16'sd900, 16'sd3};
        out2 = '{-16'sd7, 16'sd250, -16'sd1000, 16'sd250, 16'sd0};
        out3 = '{16'sd1, 16'sd2, 16'sd3, 16'sd4, 16'sd5};

        bus.s_valid            = 1'b0;
        bus.s_data             = '0;
        bus.nn_output_ready    = 1'b0;
        bus.nn_output_data     = '0;
        bus.m_ready            = 1'b0;
        bus_wd.s_valid         = 1'b0;
        bus_wd.s_data          = '0;
        bus_wd.nn_output_ready = 1'b0;
        bus_wd.nn_output_data  = '0;
        bus_wd.m_ready         = 1'b0;

        test_reset();
        test_frame1();
        test_backpressure();
        test_stale_level();
        test_watchdog();
        test_reset_mid();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
